// File: rtl/sfi_guard.sv
// Pipelined software-fault-isolation address guard: tag-matches each address against a region table.
// Optional macro SFI_STALL_ON_FAULT_EN blocks new addresses while a fault is recorded.
module sfi_guard #(
    parameter int unsigned      ADDR_W      = 32,
    parameter int unsigned      TAG_W       = 8,
    parameter int unsigned      NUM_REGIONS = 4,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [TAG_W-1:0] RESET_TAG   = 8'hA2,
    localparam int unsigned     IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [TAG_W-1:0]  cfg_tag,
    input  logic              cfg_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_ok,
    output logic [IDX_W-1:0]  out_region,
    output logic [CNT_W-1:0]  viol_count,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr
);

    logic [TAG_W-1:0]       r_tag [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] r_en;

    logic                   r_out_valid;
    logic [ADDR_W-1:0]      r_out_addr;
    logic                   r_out_ok;
    logic [IDX_W-1:0]       r_out_region;
    logic [CNT_W-1:0]       r_viol_count;
    logic                   r_fault;
    logic [ADDR_W-1:0]      r_fault_addr;

    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_miss;
    logic [ADDR_W-1:0]      w_san_addr;

    assign w_tag = in_addr[ADDR_W-1 -: TAG_W];

    // Ascending scan with an early-out flag so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!w_hit && r_en[i] && (r_tag[i] == w_tag)) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

`ifdef SFI_STALL_ON_FAULT_EN
    assign w_ready = (!r_out_valid || out_ready) && !r_fault;
`else
    assign w_ready = !r_out_valid || out_ready;
`endif

    assign w_accept   = in_valid && w_ready;
    assign w_miss     = w_accept && !w_hit;
    assign w_san_addr = w_hit ? in_addr
                      : (mode ? {r_tag[0], in_addr[ADDR_W-TAG_W-1:0]} : '0);

    // Out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_tag[i] <= (i == 0) ? RESET_TAG : '0;
            end
            r_en <= NUM_REGIONS'(1);
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    r_tag[i] <= cfg_tag;
                    r_en[i]  <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_ok     <= 1'b0;
            r_out_region <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_addr   <= w_san_addr;
            r_out_ok     <= w_hit;
            r_out_region <= w_hit ? w_idx : '0;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // A miss in the same cycle as fault_clr re-arms the record with the new address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_viol_count <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            if (w_miss && (r_viol_count != '1)) begin
                r_viol_count <= r_viol_count + 1'b1;
            end
            if (w_miss && (!r_fault || fault_clr)) begin
                r_fault      <= 1'b1;
                r_fault_addr <= in_addr;
            end else if (fault_clr) begin
                r_fault      <= 1'b0;
                r_fault_addr <= '0;
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign out_ok     = r_out_ok;
    assign out_region = r_out_region;
    assign viol_count = r_viol_count;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

endmodule
